// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the framed-byte boot loader.
package boot_loader_pkg;

    localparam int unsigned MAX_LEN           = 32;
    localparam int unsigned CSUM_W            = 8;
    localparam int unsigned LEN_W             = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/boot_csum_acc.sv
// Modular 8-bit checksum accumulator; o_zero_c flags that adding i_data
// to the running sum would give zero, so the closing byte is judged on acceptance.
module boot_csum_acc
    import boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_add,
    input  logic [CSUM_W-1:0] i_data,
    output logic              o_zero_c
);

    logic [CSUM_W-1:0] r_sum;
    logic [CSUM_W-1:0] w_next;

    assign w_next   = r_sum + i_data;
    assign o_zero_c = (w_next == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= w_next;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Frame parser that loads CPU memory through the external write port and
// releases the CPU after a verified run frame. BOOT_LOADER_TIMEOUT_EN adds an inter-byte timeout.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 5,
    parameter int unsigned       DATA_W      = 8,
`ifdef BOOT_LOADER_TIMEOUT_EN
    parameter int unsigned       TIMEOUT_CYC = 1000,
`endif
    parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(SYNC_BYTE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ewr,
    output logic [ADDR_W-1:0] ead,
    output logic [DATA_W-1:0] edat,
    output logic              cpu_run,
    output logic              frame_ok,
    output logic              err
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_run_flag;
    logic              r_ewr;
    logic [ADDR_W-1:0] r_ead;
    logic [DATA_W-1:0] r_edat;
    logic              r_cpu_run;
    logic              r_frame_ok;
    logic              r_err;

    logic w_xfer;
    logic w_is_sync;
    logic w_in_frame;
    logic w_csum_clr;
    logic w_csum_add;
    logic w_csum_zero;

    assign in_ready   = (r_state != ST_RUN);
    assign w_xfer     = in_valid && in_ready;
    assign w_is_sync  = (in_data == SYNC_BYTE);
    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                        (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_csum_clr = w_xfer && w_is_sync && ((r_state == ST_IDLE) || (r_state == ST_ERR));
    assign w_csum_add = w_xfer && w_in_frame;

    boot_csum_acc u_csum (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_csum_clr),
        .i_add    (w_csum_add),
        .i_data   (CSUM_W'(in_data)),
        .o_zero_c (w_csum_zero)
    );

`ifdef BOOT_LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;

    assign w_timeout = w_in_frame && !w_xfer && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Idle-cycle counter, only meaningful while a frame is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (!w_in_frame || w_xfer || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_rem      <= '0;
            r_run_flag <= 1'b0;
            r_ewr      <= 1'b0;
            r_ead      <= '0;
            r_edat     <= '0;
            r_cpu_run  <= 1'b0;
            r_frame_ok <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ewr      <= 1'b0;
            r_frame_ok <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && w_is_sync) begin
                        r_state <= ST_ADDR;
                    end
                end
                ST_ERR: begin
                    if (w_xfer && w_is_sync) begin
                        r_err   <= 1'b0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_xfer) begin
                        r_ptr   <= in_data[ADDR_W-1:0];
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (w_xfer) begin
                        if (in_data > DATA_W'(MAX_LEN)) begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                        end else if (in_data == '0) begin
                            r_run_flag <= 1'b1;
                            r_state    <= ST_CSUM;
                        end else begin
                            r_run_flag <= 1'b0;
                            r_rem      <= LEN_W'(in_data);
                            r_state    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Every accepted byte is data here, SYNC included
                    if (w_xfer) begin
                        r_ewr  <= 1'b1;
                        r_ead  <= r_ptr;
                        r_edat <= in_data;
                        r_ptr  <= r_ptr + ADDR_W'(1);
                        r_rem  <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_xfer) begin
                        if (w_csum_zero) begin
                            r_frame_ok <= 1'b1;
                            if (r_run_flag) begin
                                r_cpu_run <= 1'b1;
                                r_state   <= ST_RUN;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_RUN: begin
                    r_cpu_run <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef BOOT_LOADER_TIMEOUT_EN
            if (w_timeout) begin
                r_err   <= 1'b1;
                r_state <= ST_ERR;
            end
`endif
        end
    end

    assign ewr      = r_ewr;
    assign ead      = r_ead;
    assign edat     = r_edat;
    assign cpu_run  = r_cpu_run;
    assign frame_ok = r_frame_ok;
    assign err      = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader; honours BOOT_LOADER_TIMEOUT_EN.
module tb_boot_loader;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ewr;
    logic [4:0] ead;
    logic [7:0] edat;
    logic       cpu_run;
    logic       frame_ok;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int wr_n     = 0;
    int fok_n    = 0;
    logic [4:0] wr_addr [64];
    logic [7:0] wr_data [64];

    always #5 clk = ~clk;

`ifdef BOOT_LOADER_TIMEOUT_EN
    boot_loader #(.TIMEOUT_CYC(20)) dut (
`else
    boot_loader dut (
`endif
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ewr      (ewr),
        .ead      (ead),
        .edat     (edat),
        .cpu_run  (cpu_run),
        .frame_ok (frame_ok),
        .err      (err)
    );

    // Record every write strobe and frame_ok pulse just after the edge
    always @(posedge clk) begin
        #1;
        if (ewr && wr_n < 64) begin
            wr_addr[wr_n] = ead;
            wr_data[wr_n] = edat;
            wr_n++;
        end
        if (frame_ok) fok_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        wr_n  = 0;
        fok_n = 0;
    endtask

    task automatic send(input bq_t q);
        foreach (q[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = q[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int first, input logic [4:0] addr0, input bq_t d);
        logic [4:0] a;
        foreach (d[i]) begin
            a = addr0 + 5'(i);
            check({tag, "_ead"},  32'(wr_addr[first + i]), 32'(a));
            check({tag, "_edat"}, 32'(wr_data[first + i]), 32'(d[i]));
        end
    endtask

    initial begin
        bq_t load_d, f;
        load_d = '{8'hA5, 8'hA4, 8'h01, 8'h07, 8'hAA, 8'hB3, 8'h47, 8'hFE, 8'hF6, 8'h00};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ewr",      32'(ewr),      32'd0);
        check("rst_ead",      32'(ead),      32'd0);
        check("rst_edat",     32'(edat),     32'd0);
        check("rst_cpu_run",  32'(cpu_run),  32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Program load, includes a data byte equal to SYNC
        f = '{8'hA5, 8'h00, 8'h0A};
        f = {f, load_d, 8'h0D};
        send(f);
        repeat (3) @(negedge clk);
        check("load_nwr", 32'(wr_n), 32'd10);
        check_writes("load", 0, 5'd0, load_d);
        check("load_fok",     32'(fok_n),    32'd1);
        check("load_cpu_run", 32'(cpu_run),  32'd0);
        check("load_err",     32'(err),      32'd0);
        check("load_ready",   32'(in_ready), 32'd1);

        // Data load then run frame
        do_reset();
        send('{8'hA5, 8'h14, 8'h03, 8'h0F, 8'h55, 8'h05, 8'h80});
        send('{8'hA5, 8'h00, 8'h00, 8'h00});
        repeat (3) @(negedge clk);
        check("run_nwr", 32'(wr_n), 32'd3);
        check_writes("run", 0, 5'd20, '{8'h0F, 8'h55, 8'h05});
        check("run_fok",     32'(fok_n),    32'd2);
        check("run_cpu_run", 32'(cpu_run),  32'd1);
        check("run_ready",   32'(in_ready), 32'd0);
        send('{8'hA5, 8'h00});
        check("run_hold", 32'(cpu_run), 32'd1);
        // cpu_run must drop without waiting for a clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_cpu_run", 32'(cpu_run),  32'd0);
        check("async_ready",   32'(in_ready), 32'd1);

        // Pointer wrap 31 -> 0
        do_reset();
        send('{8'hA5, 8'h1E, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h34});
        repeat (2) @(negedge clk);
        check("wrap_nwr", 32'(wr_n), 32'd4);
        check_writes("wrap", 0, 5'd30, '{8'h11, 8'h22, 8'h33, 8'h44});
        check("wrap_fok", 32'(fok_n), 32'd1);
        check("wrap_err", 32'(err),   32'd0);

        // Bad checksum: writes land, err set, SYNC recovers
        do_reset();
        f = '{8'hA5, 8'h00, 8'h0A};
        f = {f, load_d, 8'h0E};
        send(f);
        repeat (2) @(negedge clk);
        check("bad_nwr",     32'(wr_n),     32'd10);
        check("bad_err",     32'(err),      32'd1);
        check("bad_fok",     32'(fok_n),    32'd0);
        check("bad_cpu_run", 32'(cpu_run),  32'd0);
        check("bad_ready",   32'(in_ready), 32'd1);
        send('{8'h33});
        check("bad_nonsync", 32'(err), 32'd1);
        send('{8'hA5});
        check("bad_clear", 32'(err), 32'd0);
        send('{8'h00, 8'h00, 8'h00});
        repeat (2) @(negedge clk);
        check("bad_run",     32'(cpu_run), 32'd1);
        check("bad_run_fok", 32'(fok_n),   32'd1);

        // LEN above maximum
        do_reset();
        send('{8'hA5, 8'h00, 8'h21});
        repeat (2) @(negedge clk);
        check("len_err",   32'(err),      32'd1);
        check("len_nwr",   32'(wr_n),     32'd0);
        check("len_ready", 32'(in_ready), 32'd1);

        // 50-cycle gap inside a frame
        do_reset();
        send('{8'hA5, 8'h05, 8'h01});
        repeat (50) @(negedge clk);
        send('{8'h5A, 8'hA0});
        repeat (2) @(negedge clk);
`ifdef BOOT_LOADER_TIMEOUT_EN
        check("stall_err", 32'(err),   32'd1);
        check("stall_nwr", 32'(wr_n),  32'd0);
        check("stall_fok", 32'(fok_n), 32'd0);
`else
        check("stall_err", 32'(err),   32'd0);
        check("stall_nwr", 32'(wr_n),  32'd1);
        check_writes("stall", 0, 5'd5, '{8'h5A});
        check("stall_fok", 32'(fok_n), 32'd1);
`endif

        // Reset in the middle of DATA
        do_reset();
        send('{8'hA5, 8'h00, 8'h0A, 8'hA5, 8'hA4, 8'h01});
        rst = 1'b1;
        #1;
        check("mid_ewr",      32'(ewr),      32'd0);
        check("mid_ead",      32'(ead),      32'd0);
        check("mid_edat",     32'(edat),     32'd0);
        check("mid_err",      32'(err),      32'd0);
        check("mid_frame_ok", 32'(frame_ok), 32'd0);
        check("mid_cpu_run",  32'(cpu_run),  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_nwr", 32'(wr_n), 32'd3);
        send('{8'hA5, 8'h1E, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h34});
        repeat (2) @(negedge clk);
        check("mid_reload_nwr", 32'(wr_n), 32'd7);
        check_writes("mid_reload", 3, 5'd30, '{8'h11, 8'h22, 8'h33, 8'h44});
        check("mid_reload_fok", 32'(fok_n), 32'd1);
        check("mid_reload_err", 32'(err),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
